uart_transceiver: RTL



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_transceiver.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
// Holds parity mode, TX/RX state encodings and the baud divider calculation.
// No ports; imported by uart_transceiver.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   // Clock cycles per oversample tick, truncated.
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      return clk_hz / (baud * os);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received characters; head_o is valid whenever valid_o is set.
// Latency: a push is visible on head_o/count_o after one edge; a pop exposes the next entry after one edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle (the pop frees the slot first).
// Ports: push_i/push_data_i write side, pop_i/head_o/valid_o read side, full_o and count_o occupancy.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             head_o,
   output logic                         valid_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: TX FSM, oversampled RX FSM with parity/framing/overrun detection, receive FIFO.
// Latency: serial_out/tx_busy follow an accept by one edge; RX push one cycle after the stop-bit sample.
// Backpressure: tx_ready gates new characters; a full RX FIFO drops the character and raises overrun.
// Ports: tx_data/tx_valid/tx_ready/tx_busy/serial_out transmit side; serial_in/rx_data/rx_valid/
// rx_read/rx_count receive side; framing_error/parity_error/overrun sticky, cleared by err_clear.
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int BAUD          = 9600,
   parameter int OVERSAMPLE    = 16,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [DATA_BITS-1:0]                 tx_data,
   input  logic                                 tx_valid,
   output logic                                 tx_ready,
   output logic                                 tx_busy,
   output logic                                 serial_out,
   input  logic                                 serial_in,
   output logic [DATA_BITS-1:0]                 rx_data,
   output logic                                 rx_valid,
   input  logic                                 rx_read,
   output logic [$clog2(RX_FIFO_DEPTH+1)-1:0]   rx_count,
   output logic                                 framing_error,
   output logic                                 parity_error,
   output logic                                 overrun,
   input  logic                                 err_clear
);

   localparam int      DIV        = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int      BIT_CYCLES = DIV * OVERSAMPLE;
   localparam int      DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int      BC_W       = $clog2(BIT_CYCLES);
   localparam int      OS_W       = $clog2(OVERSAMPLE);
   localparam int      BIT_W      = $clog2(DATA_BITS);
   localparam parity_e PAR_MODE   = parity_e'(PARITY);
   localparam bit      HAS_PAR    = (PAR_MODE != PAR_NONE);
   localparam bit      PAR_INV    = (PAR_MODE == PAR_ODD);

   // ---------------- oversample tick ----------------
   logic [DIV_W-1:0] div_cnt_q;
   logic             tick;

   assign tick = (div_cnt_q == DIV_W'(DIV-1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     div_cnt_q <= '0;
      else if (tick) div_cnt_q <= '0;
      else           div_cnt_q <= div_cnt_q + DIV_W'(1);
   end

   // ---------------- transmitter ----------------
   tx_state_e            tx_state_q;
   logic [BC_W-1:0]      tx_cnt_q;
   logic [BIT_W-1:0]     tx_bit_q;
   logic [DATA_BITS-1:0] tx_shift_q;
   logic                 tx_par_q;
   logic                 tx_ready_q;
   logic                 tx_busy_q;
   logic                 serial_out_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q   <= TX_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_par_q     <= 1'b0;
         tx_ready_q   <= 1'b1;
         tx_busy_q    <= 1'b0;
         serial_out_q <= 1'b1;
      end else begin
         // Line outputs are registered from the current state, so they trail it by one edge.
         unique case (tx_state_q)
            TX_START:  serial_out_q <= 1'b0;
            TX_DATA:   serial_out_q <= tx_shift_q[0];
            TX_PARITY: serial_out_q <= tx_par_q;
            default:   serial_out_q <= 1'b1;
         endcase
         tx_busy_q <= (tx_state_q != TX_IDLE);

         if (tx_state_q == TX_IDLE) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            if (tx_valid && tx_ready_q) begin
               tx_state_q <= TX_START;
               tx_shift_q <= tx_data;
               tx_par_q   <= (^tx_data) ^ PAR_INV;
               tx_ready_q <= 1'b0;
            end
         end else if (tx_cnt_q != BC_W'(BIT_CYCLES-1)) begin
            tx_cnt_q <= tx_cnt_q + BC_W'(1);
         end else begin
            tx_cnt_q <= '0;
            unique case (tx_state_q)
               TX_START: tx_state_q <= TX_DATA;
               TX_DATA: begin
                  tx_shift_q <= tx_shift_q >> 1;
                  if (tx_bit_q == BIT_W'(DATA_BITS-1)) begin
                     tx_bit_q   <= '0;
                     tx_state_q <= HAS_PAR ? TX_PARITY : TX_STOP;
                  end else begin
                     tx_bit_q <= tx_bit_q + BIT_W'(1);
                  end
               end
               TX_PARITY: tx_state_q <= TX_STOP;
               default: begin
                  tx_state_q <= TX_IDLE;
                  tx_ready_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign tx_ready   = tx_ready_q;
   assign tx_busy    = tx_busy_q;
   assign serial_out = serial_out_q;

   // ---------------- receiver ----------------
   logic [1:0]           rx_sync_q;
   logic                 rx_in;
   rx_state_e            rx_state_q;
   logic [OS_W-1:0]      rx_os_q;
   logic [BIT_W-1:0]     rx_bit_q;
   logic [DATA_BITS-1:0] rx_shift_q;
   logic                 rx_push_q;
   logic                 fe_set_q;
   logic                 pe_set_q;

   // Reset to idle-high so a reset release never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_sync_q <= 2'b11;
      else       rx_sync_q <= {rx_sync_q[0], serial_in};
   end
   assign rx_in = rx_sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         rx_os_q    <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_push_q  <= 1'b0;
         fe_set_q   <= 1'b0;
         pe_set_q   <= 1'b0;
      end else begin
         rx_push_q <= 1'b0;
         fe_set_q  <= 1'b0;
         pe_set_q  <= 1'b0;
         if (tick) begin
            unique case (rx_state_q)
               RX_IDLE: begin
                  rx_os_q  <= '0;
                  rx_bit_q <= '0;
                  if (!rx_in) rx_state_q <= RX_START;
               end
               RX_START: begin
                  // Half a bit later we are mid-start; a high line here was a glitch.
                  if (rx_os_q == OS_W'(OVERSAMPLE/2-1)) begin
                     rx_os_q    <= '0;
                     rx_state_q <= rx_in ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_os_q <= rx_os_q + OS_W'(1);
                  end
               end
               RX_DATA: begin
                  if (rx_os_q == OS_W'(OVERSAMPLE-1)) begin
                     rx_os_q    <= '0;
                     rx_shift_q <= {rx_in, rx_shift_q[DATA_BITS-1:1]};
                     if (rx_bit_q == BIT_W'(DATA_BITS-1)) begin
                        rx_bit_q   <= '0;
                        rx_state_q <= HAS_PAR ? RX_PARITY : RX_STOP;
                     end else begin
                        rx_bit_q <= rx_bit_q + BIT_W'(1);
                     end
                  end else begin
                     rx_os_q <= rx_os_q + OS_W'(1);
                  end
               end
               RX_PARITY: begin
                  if (rx_os_q == OS_W'(OVERSAMPLE-1)) begin
                     rx_os_q    <= '0;
                     pe_set_q   <= (rx_in != ((^rx_shift_q) ^ PAR_INV));
                     rx_state_q <= RX_STOP;
                  end else begin
                     rx_os_q <= rx_os_q + OS_W'(1);
                  end
               end
               RX_STOP: begin
                  if (rx_os_q == OS_W'(OVERSAMPLE-1)) begin
                     rx_os_q <= '0;
                     if (rx_in) begin
                        rx_push_q  <= 1'b1;
                        rx_state_q <= RX_IDLE;
                     end else begin
                        fe_set_q   <= 1'b1;
                        rx_state_q <= RX_BREAK;
                     end
                  end else begin
                     rx_os_q <= rx_os_q + OS_W'(1);
                  end
               end
               default: begin
                  if (rx_in) rx_state_q <= RX_IDLE;
               end
            endcase
         end
      end
   end

   // ---------------- receive FIFO ----------------
   logic fifo_full;
   logic ovr_set;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (rx_push_q),
      .push_data_i (rx_shift_q),
      .pop_i       (rx_read),
      .head_o      (rx_data),
      .valid_o     (rx_valid),
      .full_o      (fifo_full),
      .count_o     (rx_count)
   );

   // A simultaneous pop frees the slot, so only an unaccompanied push into a full FIFO overruns.
   assign ovr_set = rx_push_q && fifo_full && !rx_read;

   // ---------------- sticky error flags ----------------
   logic fe_q, pe_q, ovr_q;
   logic fe_d, pe_d, ovr_d;

   always_comb begin
      fe_d  = fe_q;
      pe_d  = pe_q;
      ovr_d = ovr_q;
      if (err_clear) begin
         fe_d  = 1'b0;
         pe_d  = 1'b0;
         ovr_d = 1'b0;
      end
      // A new error in the same cycle as err_clear is kept.
      if (fe_set_q) fe_d  = 1'b1;
      if (pe_set_q) pe_d  = 1'b1;
      if (ovr_set)  ovr_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fe_q  <= 1'b0;
         pe_q  <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         fe_q  <= fe_d;
         pe_q  <= pe_d;
         ovr_q <= ovr_d;
      end
   end

   assign framing_error = fe_q;
   assign parity_error  = pe_q;
   assign overrun       = ovr_q;

endmodule
